// File: rtl/pz_scan_ctrl.sv
// Frame scan controller: double-buffered pole/zero bank plus a raster
// coordinate generator with a valid/ready output toward the subtractor.
module pz_scan_ctrl #(
   parameter int H_RES = 640,
   parameter int V_RES = 480
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_we,
   input  logic [3:0]  cfg_addr,
   input  logic [31:0] cfg_wdata,
   input  logic        cfg_commit,
   input  logic        start,
   output logic        busy,
   output logic        frame_done,
   output logic        commit_pending,
   output logic [15:0] x,
   output logic [15:0] y,
   output logic        sof,
   output logic        eol,
   output logic        eof,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] zero_0,
   output logic [31:0] zero_1,
   output logic [31:0] zero_2,
   output logic [31:0] zero_3,
   output logic [31:0] pole_0,
   output logic [31:0] pole_1,
   output logic [31:0] pole_2,
   output logic [31:0] pole_3
);

   localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(H_RES - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(V_RES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

   state_t        state;
   logic [31:0]   sh_pz  [8];
   logic [31:0]   act_pz [8];
   logic [31:0]   nxt_pz [8];
   logic [15:0]   sh_xs, sh_ys, sh_step;
   logic [15:0]   act_xs, act_ys, act_step;
   logic [15:0]   nxt_xs, nxt_ys, nxt_step;
   logic [CW-1:0] col;
   logic [RW-1:0] row;

   // Shadow bank as it will be after this cycle's write; commits copy this
   // so a write landing with cfg_commit is included.
   always_comb begin
      nxt_pz   = sh_pz;
      nxt_xs   = sh_xs;
      nxt_ys   = sh_ys;
      nxt_step = sh_step;
      if (cfg_we) begin
         unique case (1'b1)
            !cfg_addr[3]: nxt_pz[cfg_addr[2:0]] = cfg_wdata;
            cfg_addr == 4'd8: begin
               nxt_xs = cfg_wdata[31:16];
               nxt_ys = cfg_wdata[15:0];
            end
            cfg_addr == 4'd9: nxt_step = cfg_wdata[15:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         sh_pz          <= '{default: '0};
         act_pz         <= '{default: '0};
         sh_xs          <= '0;
         sh_ys          <= '0;
         sh_step        <= 16'h0001;
         act_xs         <= '0;
         act_ys         <= '0;
         act_step       <= 16'h0001;
         col            <= '0;
         row            <= '0;
         x              <= '0;
         y              <= '0;
         busy           <= 1'b0;
         frame_done     <= 1'b0;
         commit_pending <= 1'b0;
         out_valid      <= 1'b0;
      end else begin
         sh_pz      <= nxt_pz;
         sh_xs      <= nxt_xs;
         sh_ys      <= nxt_ys;
         sh_step    <= nxt_step;
         frame_done <= 1'b0;
         if (cfg_commit) commit_pending <= 1'b1;
         unique case (state)
            IDLE: begin
               if (cfg_commit) begin
                  act_pz         <= nxt_pz;
                  act_xs         <= nxt_xs;
                  act_ys         <= nxt_ys;
                  act_step       <= nxt_step;
                  commit_pending <= 1'b0;
               end
               if (start) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               if (commit_pending) begin
                  act_pz         <= nxt_pz;
                  act_xs         <= nxt_xs;
                  act_ys         <= nxt_ys;
                  act_step       <= nxt_step;
                  commit_pending <= cfg_commit;
               end
               col       <= '0;
               row       <= '0;
               x         <= commit_pending ? nxt_xs : act_xs;
               y         <= commit_pending ? nxt_ys : act_ys;
               out_valid <= 1'b1;
               state     <= SCAN;
            end
            SCAN: begin
               if (out_valid && out_ready) begin
                  if (col != COL_LAST) begin
                     col <= col + CW'(1);
                     x   <= x + act_step;
                  end else if (row != ROW_LAST) begin
                     col <= '0;
                     row <= row + RW'(1);
                     x   <= act_xs;
                     y   <= y - act_step;
                  end else begin
                     out_valid  <= 1'b0;
                     frame_done <= 1'b1;
                     state      <= DONE;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign sof = out_valid && (col == '0) && (row == '0);
   assign eol = out_valid && (col == COL_LAST);
   assign eof = eol && (row == ROW_LAST);

   assign zero_0 = act_pz[0];
   assign zero_1 = act_pz[1];
   assign zero_2 = act_pz[2];
   assign zero_3 = act_pz[3];
   assign pole_0 = act_pz[4];
   assign pole_1 = act_pz[5];
   assign pole_2 = act_pz[6];
   assign pole_3 = act_pz[7];

endmodule

// File: tb/tb_pz_scan_ctrl.sv
// Directed bench for pz_scan_ctrl on a 4x3 frame.
module tb_pz_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [3:0]  cfg_addr = '0;
   logic [31:0] cfg_wdata = '0;
   logic        cfg_commit = 1'b0;
   logic        start = 1'b0;
   logic        out_ready = 1'b0;
   logic        busy, frame_done, commit_pending;
   logic [15:0] x, y;
   logic        sof, eol, eof, out_valid;
   logic [31:0] zero_0, zero_1, zero_2, zero_3;
   logic [31:0] pole_0, pole_1, pole_2, pole_3;

   int checks = 0;
   int failures = 0;

   pz_scan_ctrl #(.H_RES(4), .V_RES(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
      .start(start), .busy(busy), .frame_done(frame_done),
      .commit_pending(commit_pending),
      .x(x), .y(y), .sof(sof), .eol(eol), .eof(eof),
      .out_valid(out_valid), .out_ready(out_ready),
      .zero_0(zero_0), .zero_1(zero_1),
      .zero_2(zero_2), .zero_3(zero_3),
      .pole_0(pole_0), .pole_1(pole_1),
      .pole_2(pole_2), .pole_3(pole_3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic start_frame();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("load_busy", 32'(busy), 32'd1);
      check("load_nvalid", 32'(out_valid), 32'd0);
      tick();
      check("first_valid", 32'(out_valid), 32'd1);
   endtask

   // mode 0: ready high, 1: random throttle,
   // 2: start pulse mid-frame, 3: write+commit mid-frame
   task automatic run_frame(input logic [15:0] xs, input logic [15:0] ys,
                            input int mode);
      int idx = 0;
      int cyc = 0;
      bit stalled = 0;
      bit did = 0;
      logic [31:0] hold_xy = '0;
      logic [31:0] hold_f = '0;
      logic [31:0] exp_xy;
      int c_col, c_row;
      for (int c = 0; c < 400 && idx < 12; c++) begin
         if (stalled) begin
            check("stall_xy", {x, y}, hold_xy);
            check("stall_flags", 32'({sof, eol, eof}), hold_f);
         end
         check("scan_valid", 32'(out_valid), 32'd1);
         out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         start = (mode == 2 && idx == 5 && !did);
         if (mode == 3 && idx == 2 && !did) begin
            cfg_we = 1'b1; cfg_addr = 4'd4;
            cfg_wdata = 32'h0005_0003; cfg_commit = 1'b1;
         end
         if (out_valid && out_ready) begin
            c_col = idx % 4;
            c_row = idx / 4;
            exp_xy = {16'(int'(xs) + c_col), 16'(int'(ys) - c_row)};
            check("pix_xy", {x, y}, exp_xy);
            check("pix_flags", 32'({sof, eol, eof}),
                  32'({idx == 0, c_col == 3, idx == 11}));
            idx++;
            stalled = 0;
         end else begin
            stalled = 1;
            hold_xy = {x, y};
            hold_f = 32'({sof, eol, eof});
         end
         cyc++;
         tick();
         if (start) begin
            start = 1'b0;
            did = 1;
         end
         if (cfg_commit) begin
            cfg_we = 1'b0; cfg_commit = 1'b0;
            did = 1;
            check("pole_hold", pole_0, 32'd0);
            check("pend_set", 32'(commit_pending), 32'd1);
         end
      end
      check("frame_len", idx, 12);
      if (mode != 1) check("scan_cycles", cyc, 12);
      check("done_pulse", 32'(frame_done), 32'd1);
      check("done_nvalid", 32'(out_valid), 32'd0);
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_fd", 32'(frame_done), 32'd0);
      tick();
      check("no_queued", 32'(busy), 32'd0);
   endtask

   initial begin
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_pend", 32'(commit_pending), 32'd0);
      check("rst_xy", {x, y}, 32'd0);
      check("rst_flags", 32'({frame_done, sof, eol, eof}), 32'd0);
      check("rst_pole0", pole_0, 32'd0);
      rst_n = 1'b1;
      tick();

      cfg_write(4'd8, 32'hFFFE_0001);
      cfg_write(4'd9, 32'h0000_0001);
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      start_frame();
      run_frame(16'hFFFE, 16'h0001, 0);

      start_frame();
      run_frame(16'hFFFE, 16'h0001, 1);

      cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 32'h1234_5678;
      cfg_commit = 1'b1;
      tick();
      cfg_we = 1'b0; cfg_commit = 1'b0;
      check("same_cyc_zero0", zero_0, 32'h1234_5678);

      start_frame();
      run_frame(16'hFFFE, 16'h0001, 3);
      check("idle_pend", 32'(commit_pending), 32'd1);
      check("idle_pole0", pole_0, 32'd0);
      start_frame();
      check("load_pole0", pole_0, 32'h0005_0003);
      check("load_pend_clr", 32'(commit_pending), 32'd0);
      run_frame(16'hFFFE, 16'h0001, 0);

      cfg_write(4'd8, 32'h7FFF_0001);
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      start_frame();
      run_frame(16'h7FFF, 16'h0001, 2);

      start_frame();
      out_ready = 1'b1;
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      check("pre_rst_pend", 32'(commit_pending), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_pend", 32'(commit_pending), 32'd0);
      check("mid_rst_zero0", zero_0, 32'd0);
      check("mid_rst_pole0", pole_0, 32'd0);
      check("mid_rst_xy", {x, y}, 32'd0);
      tick();
      check("mid_rst_nofd", 32'(frame_done), 32'd0);
      start_frame();
      run_frame(16'h0000, 16'h0000, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
